frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_ROW, default 6, frames per pattern row (range 1..64).
REQ-002 SHALL have parameter ROW_BITS, default 4, log2 rows per pattern.
REQ-003 SHALL have parameter PATTERN_BITS, default 3, pattern index width.
REQ-004 SHALL have parameter LOOP_PATTERN, default 2, pattern index that follows LAST_PATTERN.
REQ-005 SHALL have parameter LAST_PATTERN, default 7, final pattern index before looping.
REQ-006 SHALL have parameter CTRL_BITS, default 8, width of the per-row player control word.
REQ-007 SHALL have ports clk (input, 1): the single clock; reset (input, 1): synchronous, active-high reset.
REQ-008 SHALL have port new_frame (input, 1): one-cycle pulse at each frame start.
REQ-009 SHALL have port pause (input, 1): level; when high, frames do not advance the song position.
REQ-010 SHALL have port restart (input, 1): one-cycle pulse; returns the song position to pattern 0, row 0.
REQ-011 SHALL have port rom_req (output, 1): fetch request to the pattern ROM.
REQ-012 SHALL have port rom_addr (output, PATTERN_BITS+ROW_BITS): {pattern, row}, stable while rom_req is high.
REQ-013 SHALL have ports rom_valid (input, 1) and rom_data (input, CTRL_BITS): ROM response, valid for one cycle.
REQ-014 SHALL have port control (output, CTRL_BITS): registered player control word.
REQ-015 SHALL have port control_update (output, 1): one-cycle pulse when control changes.
REQ-016 SHALL have port raise_drum (output, 1): drum trigger level.
REQ-017 SHALL have port frame_overrun (output, 1): sticky error flag.

Function
REQ-018 SHALL hold the song position in internal counters tick (0..TICKS_PER_ROW-1), row (ROW_BITS) and pattern (PATTERN_BITS).
REQ-019 SHALL implement states IDLE, FETCH and APPLY.
REQ-020 In IDLE, an accepted frame with pause low SHALL increment tick; at tick=TICKS_PER_ROW-1 it SHALL instead clear tick, increment row and enter FETCH in the next cycle.
REQ-021 Row wrap from all-ones to 0 SHALL advance pattern; advancing from LAST_PATTERN SHALL load LOOP_PATTERN.
REQ-022 In IDLE, an accepted frame with pause high SHALL change nothing; tick, row and pattern are frozen and no fetch starts.
REQ-023 In FETCH, the block SHALL hold rom_req=1 and rom_addr={pattern,row} until a cycle with rom_valid=1, then enter APPLY.
REQ-024 In APPLY (one cycle), the block SHALL register control<=rom_data from the rom_valid cycle, pulse control_update, and return to IDLE.
REQ-025 Latency SHALL be as follows: new_frame at cycle t causing row advance gives rom_req=1 at t+1; rom_valid at cycle u gives the control change and control_update at u+1.
REQ-026 rom_valid outside FETCH SHALL be ignored.
REQ-027 A new_frame arriving in FETCH or APPLY SHALL set a one-deep pending flag, which IDLE SHALL process in its first cycle as an accepted frame.
REQ-028 A new_frame arriving while pending is already set SHALL be dropped and SHALL set frame_overrun.
REQ-029 frame_overrun SHALL clear only on reset.
REQ-030 restart in IDLE SHALL take effect the next cycle: tick=0, row=0, pattern=0, pending cleared, then enter FETCH.
REQ-031 restart in FETCH or APPLY SHALL be latched and applied upon return to IDLE, overriding any pending frame.
REQ-032 When restart and new_frame occur in the same cycle, restart SHALL take effect and the frame SHALL be discarded.
REQ-033 raise_drum SHALL equal control[0] AND (tick==0) AND (state==IDLE), registered.
REQ-034 raise_drum SHALL be 0 while pause is high.

Reset
REQ-035 Reset SHALL clear tick, row, pattern, control, control_update, raise_drum, frame_overrun and all pending flags.
REQ-036 Reset SHALL set state to FETCH, so row 0 of pattern 0 is fetched immediately after reset.
REQ-037 While reset is high, rom_req SHALL be 0.
REQ-038 Reset mid-FETCH SHALL abandon the fetch, and a later stale rom_valid SHALL be ignored until the new FETCH begins.

Verification
REQ-039 Release reset, ROM returns 0x5A after 3 cycles -> rom_addr=0, control=0x5A with a single control_update pulse 1 cycle after rom_valid.
REQ-040 Apply 6 frames in IDLE with defaults -> fetch of row 1, rom_addr=0x01; 96 frames from pattern 0 row 0 -> pattern 1, rom_addr=0x10.
REQ-041 Advance position to pattern 7 row 15, then complete the row -> next rom_addr = {3'd2,4'd0} = 0x20.
REQ-042 Hold rom_valid low, pulse new_frame twice in FETCH -> first frame processed after APPLY, second sets frame_overrun=1, which stays set.
REQ-043 Pulse restart and new_frame together in IDLE at pattern 3 -> rom_addr=0x00 fetched, tick=0, no frame counted.
REQ-044 Hold pause high for 20 frames with control[0]=1 -> no rom_req, raise_drum=0; release pause -> advance resumes from the frozen tick.

Source files
------------

// File: rtl/frame_sequencer.sv
// Song-position sequencer: counts frames into ticks/rows/patterns and fetches
// the per-row player control word from a pattern ROM.
module frame_sequencer #(
  parameter int unsigned TICKS_PER_ROW = 6,
  parameter int unsigned ROW_BITS      = 4,
  parameter int unsigned PATTERN_BITS  = 3,
  parameter int unsigned LOOP_PATTERN  = 2,
  parameter int unsigned LAST_PATTERN  = 7,
  parameter int unsigned CTRL_BITS     = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             new_frame,
  input  logic                             pause,
  input  logic                             restart,
  output logic                             rom_req,
  output logic [PATTERN_BITS+ROW_BITS-1:0] rom_addr,
  input  logic                             rom_valid,
  input  logic [CTRL_BITS-1:0]             rom_data,
  output logic [CTRL_BITS-1:0]             control,
  output logic                             control_update,
  output logic                             raise_drum,
  output logic                             frame_overrun
);

  localparam int unsigned TICK_W = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
  localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(TICKS_PER_ROW - 1);
  localparam logic [PATTERN_BITS-1:0] PAT_LAST  = PATTERN_BITS'(LAST_PATTERN);
  localparam logic [PATTERN_BITS-1:0] PAT_LOOP  = PATTERN_BITS'(LOOP_PATTERN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [TICK_W-1:0]       r_tick, w_tick_nxt;
  logic [ROW_BITS-1:0]     r_row, w_row_nxt;
  logic [PATTERN_BITS-1:0] r_pattern, w_pattern_nxt;
  logic [CTRL_BITS-1:0]    r_control, w_control_nxt;
  logic                    r_control_update, w_control_update_nxt;
  logic                    r_raise_drum, w_raise_drum_nxt;
  logic                    r_overrun, w_overrun_nxt;
  logic                    r_pending, w_pending_nxt;
  logic                    r_restart_pend, w_restart_pend_nxt;

  logic w_restart_any;
  logic w_frame_any;
  logic w_row_end;
  logic w_advance;

  assign w_restart_any = restart | r_restart_pend;
  assign w_frame_any   = new_frame | r_pending;
  assign w_row_end     = (r_tick == TICK_LAST);
  assign w_advance     = (r_state == S_IDLE) && !w_restart_any && w_frame_any && !pause;

  // State register; reset lands in FETCH so row 0 of pattern 0 loads at once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_restart_any || (w_advance && w_row_end)) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rom_valid) begin
          w_state_nxt = S_APPLY;
        end
      end
      S_APPLY: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_tick_nxt           = r_tick;
    w_row_nxt            = r_row;
    w_pattern_nxt        = r_pattern;
    w_control_nxt        = r_control;
    w_control_update_nxt = 1'b0;
    w_overrun_nxt        = r_overrun;
    w_pending_nxt        = r_pending;
    w_restart_pend_nxt   = r_restart_pend;
    w_raise_drum_nxt     = r_control[0] && (r_tick == '0) && (r_state == S_IDLE) && !pause;

    if (r_state == S_IDLE) begin
      if (w_restart_any) begin
        w_tick_nxt         = '0;
        w_row_nxt          = '0;
        w_pattern_nxt      = '0;
        w_pending_nxt      = 1'b0;
        w_restart_pend_nxt = 1'b0;
      end else if (w_frame_any) begin
        // A pending frame is consumed first; a simultaneous new frame queues behind it
        w_pending_nxt = r_pending & new_frame;
        if (w_advance) begin
          if (w_row_end) begin
            w_tick_nxt = '0;
            w_row_nxt  = r_row + ROW_BITS'(1);
            if (&r_row) begin
              w_pattern_nxt = (r_pattern == PAT_LAST) ? PAT_LOOP : r_pattern + PATTERN_BITS'(1);
            end
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end
      end
    end else begin
      if (restart) begin
        w_restart_pend_nxt = 1'b1;
      end else if (new_frame) begin
        if (r_pending) begin
          w_overrun_nxt = 1'b1;
        end else begin
          w_pending_nxt = 1'b1;
        end
      end
      // Capture on the valid cycle so control and its pulse show up one cycle later
      if ((r_state == S_FETCH) && rom_valid) begin
        w_control_nxt        = rom_data;
        w_control_update_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick           <= '0;
      r_row            <= '0;
      r_pattern        <= '0;
      r_control        <= '0;
      r_control_update <= 1'b0;
      r_raise_drum     <= 1'b0;
      r_overrun        <= 1'b0;
      r_pending        <= 1'b0;
      r_restart_pend   <= 1'b0;
    end else begin
      r_tick           <= w_tick_nxt;
      r_row            <= w_row_nxt;
      r_pattern        <= w_pattern_nxt;
      r_control        <= w_control_nxt;
      r_control_update <= w_control_update_nxt;
      r_raise_drum     <= w_raise_drum_nxt;
      r_overrun        <= w_overrun_nxt;
      r_pending        <= w_pending_nxt;
      r_restart_pend   <= w_restart_pend_nxt;
    end
  end

  // Request is gated by reset so nothing is asked of the ROM while held
  assign rom_req        = (r_state == S_FETCH) && !reset;
  assign rom_addr       = {r_pattern, r_row};
  assign control        = r_control;
  assign control_update = r_control_update;
  assign raise_drum     = r_raise_drum;
  assign frame_overrun  = r_overrun;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a song-position reference model predicts
// fetch addresses and control words; a negedge monitor compares DUT output.
module tb_frame_sequencer;

  localparam int T    = 6;
  localparam int LOOP = 2;
  localparam int LAST = 7;

  logic       clk;
  logic       reset;
  logic       new_frame;
  logic       pause;
  logic       restart;
  logic       rom_req;
  logic [6:0] rom_addr;
  logic       rom_valid = 1'b0;
  logic [7:0] rom_data  = 8'h00;
  logic [7:0] control;
  logic       control_update;
  logic       raise_drum;
  logic       frame_overrun;

  frame_sequencer dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .pause(pause), .restart(restart),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .control(control), .control_update(control_update), .raise_drum(raise_drum),
    .frame_overrun(frame_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm, input logic [31:0] info);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: value 0x%0h (cycle %0d)", nm, info, cyc);
  endtask

  // Reference model: position kept as absolute rows played, pattern derived arithmetically
  typedef struct { logic [6:0] addr; int cyc; } fexp_t;
  typedef struct { logic [7:0] data; int cyc; } cexp_t;
  fexp_t fq[$];
  cexp_t cq[$];

  bit         m_init = 0;
  bit         m_fetching, m_applying, m_pend, m_rst_pend, m_ovr, m_drum, m_idle;
  int         m_tick, m_rows;
  logic [7:0] m_ctrl;

  function automatic logic [6:0] exp_addr(input int rows);
    int pidx, p;
    pidx = rows / 16;
    if (pidx <= LAST) p = pidx;
    else p = LOOP + (pidx - LOOP) % (LAST - LOOP + 1);
    return 7'((p % 8) * 16 + rows % 16);
  endfunction

  task automatic start_fetch();
    fexp_t e;
    m_fetching = 1;
    e.addr = exp_addr(m_rows);
    e.cyc  = cyc + 1;
    fq.push_back(e);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_tick = 0; m_rows = 0; m_pend = 0; m_rst_pend = 0;
      m_ovr = 0; m_ctrl = 8'h00; m_drum = 0; m_applying = 0;
      fq.delete(); cq.delete();
      start_fetch();
    end else if (m_init) begin
      m_idle = !m_fetching && !m_applying;
      m_drum = m_ctrl[0] && (m_tick == 0) && m_idle && !pause;
      if (!m_idle) begin
        if (restart) m_rst_pend = 1;
        else if (new_frame) begin
          if (m_pend) m_ovr = 1;
          else m_pend = 1;
        end
        if (m_applying) m_applying = 0;
        else if (rom_valid) begin
          cexp_t c;
          c.data = rom_data;
          c.cyc  = cyc + 1;
          cq.push_back(c);
          m_ctrl = rom_data;
          m_fetching = 0;
          m_applying = 1;
        end
      end else if (restart || m_rst_pend) begin
        m_tick = 0; m_rows = 0; m_pend = 0; m_rst_pend = 0;
        start_fetch();
      end else if (new_frame || m_pend) begin
        m_pend = m_pend && new_frame;
        if (!pause) begin
          m_tick++;
          if (m_tick == T) begin
            m_tick = 0;
            m_rows++;
            start_fetch();
          end
        end
      end
    end
    cyc++;
  end

  // Monitor
  logic       prev_req = 1'b0;
  logic [6:0] cur_addr = 7'h0;
  always @(negedge clk) begin
    fexp_t fe;
    cexp_t ce;
    if (m_init) begin
      if (reset) chk("req_in_reset", 32'(rom_req), 32'd0);
      if (rom_req && !prev_req) begin
        if (fq.size() == 0) note_fail("fetch_unexpected", 32'(rom_addr));
        else begin
          fe = fq.pop_front();
          chk("fetch_addr", 32'(rom_addr), 32'(fe.addr));
          chk("fetch_cycle", 32'(cyc), 32'(fe.cyc));
          cur_addr = fe.addr;
        end
      end else if (rom_req) begin
        chk("addr_hold", 32'(rom_addr), 32'(cur_addr));
      end
      if (fq.size() > 0 && fq[0].cyc < cyc) begin
        fe = fq.pop_front();
        note_fail("fetch_missing", 32'(fe.addr));
      end
      if (control_update === 1'b1) begin
        if (cq.size() == 0) note_fail("update_unexpected", 32'(control));
        else begin
          ce = cq.pop_front();
          chk("control", 32'(control), 32'(ce.data));
          chk("update_cycle", 32'(cyc), 32'(ce.cyc));
        end
      end
      if (cq.size() > 0 && cq[0].cyc < cyc) begin
        ce = cq.pop_front();
        note_fail("update_missing", 32'(ce.data));
      end
      chk("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
      chk("raise_drum", 32'(raise_drum), 32'(m_drum));
    end
    prev_req = rom_req;
  end

  // ROM responder
  int rsp_delay = 3;
  int rsp_data  = 'h5A;
  bit rsp_hold  = 0;
  bit spur_en   = 0;
  int wait_cnt  = -1;
  always @(posedge clk) begin
    #2;
    rom_valid = 1'b0;
    if (rom_req === 1'b1) begin
      if (!rsp_hold) begin
        if (wait_cnt < 0) wait_cnt = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 3));
        if (wait_cnt == 0) begin
          rom_valid = 1'b1;
          rom_data  = (rsp_data >= 0) ? 8'(rsp_data) : 8'($urandom);
          wait_cnt  = -1;
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      wait_cnt = -1;
      if (spur_en && $urandom_range(0, 5) == 0) begin
        rom_valid = 1'b1;
        rom_data  = 8'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    step(); reset = 1'b1;
    repeat (n - 1) step();
    step(); reset = 1'b0;
  endtask

  task automatic pulse_frame();
    step(); new_frame = 1'b1;
    step(); new_frame = 1'b0;
  endtask

  task automatic frames(input int n, input int gap);
    repeat (n) begin
      pulse_frame();
      idle(gap);
    end
  endtask

  task automatic wait_req(input string nm, input logic [6:0] exp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rom_req === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) note_fail("req_timeout", 32'(exp));
    else chk(nm, 32'(rom_addr), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; new_frame = 1'b0; pause = 1'b0; restart = 1'b0;

    // Reset fetch, ROM answers 0x5A after 3 cycles
    do_reset(3);
    wait_req("reset_fetch_addr", 7'h00);
    chk("control_after_reset", 32'(control), 32'h0);
    idle(8);
    chk("control_5a", 32'(control), 32'h5A);

    // Row and pattern advance
    rsp_delay = -1; rsp_data = -1;
    frames(5, 6); pulse_frame();
    wait_req("row1_addr", 7'h01);
    idle(10);
    frames(89, 6); pulse_frame();
    wait_req("pattern1_addr", 7'h10);
    idle(10);

    // Complete pattern 7 row 15 -> loop to pattern 2
    frames(671, 6); pulse_frame();
    wait_req("loop_addr", 7'h20);
    idle(10);

    // Two frames during a stalled fetch
    rsp_hold = 1;
    step(); restart = 1'b1;
    step(); restart = 1'b0;
    wait_req("stall_fetch_addr", 7'h00);
    idle(2); pulse_frame();
    idle(2); pulse_frame();
    idle(2);
    chk("overrun_set", 32'(frame_overrun), 32'd1);
    rsp_hold = 0;
    idle(15);
    chk("overrun_sticky", 32'(frame_overrun), 32'd1);

    // Restart together with a frame at pattern 3
    do_reset(2);
    idle(8);
    chk("overrun_cleared", 32'(frame_overrun), 32'd0);
    frames(288, 6);
    idle(10);
    step(); restart = 1'b1; new_frame = 1'b1;
    step(); restart = 1'b0; new_frame = 1'b0;
    wait_req("restart_addr", 7'h00);
    idle(10);
    frames(5, 6); pulse_frame();
    wait_req("restart_row1_addr", 7'h01);
    idle(10);

    // Pause freezes position and silences the drum
    rsp_data = 3;
    step(); restart = 1'b1;
    step(); restart = 1'b0;
    idle(12);
    chk("control_bit0", 32'(control), 32'h3);
    frames(2, 6);
    pause = 1'b1;
    frames(20, 4);
    chk("drum_paused", 32'(raise_drum), 32'd0);
    pause = 1'b0;
    idle(2);
    frames(3, 6); pulse_frame();
    wait_req("resume_addr", 7'h01);
    idle(10);
    chk("drum_on", 32'(raise_drum), 32'd1);

    // Randomized traffic
    rsp_data = -1; rsp_delay = -1; spur_en = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      new_frame = ($urandom_range(0, 3) == 0);
      restart   = ($urandom_range(0, 96) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) pause = ~pause;
    end
    step();
    new_frame = 1'b0; restart = 1'b0; reset = 1'b0; pause = 1'b0; spur_en = 0;
    idle(20);
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("update_queue_drained", 32'(cq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
